bin_to_bcd_seq: RTL and testbench



---
 rtl/bin_to_bcd_seq_pkg.sv | 26 ++
 rtl/bin_to_bcd_seq_if.sv | 26 ++
 rtl/bin_to_bcd_seq_bcd_add3.sv | 7 +
 rtl/bin_to_bcd_seq.sv | 127 ++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared display definitions (digit codes, FSM encoding) and formatter-local constants.
package yoda_display_defs;
   localparam logic [4:0] DIGIT_BLANK = 5'h1F;
   localparam logic [4:0] DIGIT_DASH  = 5'h10;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SHIFT  = 2'b01,
      FORMAT = 2'b10
   } state_e;
endpackage

package bin_to_bcd_seq_pkg;
   localparam int unsigned DIGIT_W    = 5;
   localparam int unsigned NIBBLE_W   = 4;
   localparam int unsigned OUT_DIGITS = 4;
   localparam int unsigned CNT_W      = 5;

   // Largest value representable with the given number of decimal digits.
   function automatic int unsigned max_value(input int unsigned digits);
      int unsigned p;
      p = 1;
      for (int i = 0; i < int'(digits); i++) p = p * 10;
      return p - 1;
   endfunction
endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between the result register, the formatter and the display driver.
interface bin_to_bcd_seq_if
   import bin_to_bcd_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 14
);
   logic               start;
   logic [WIDTH-1:0]   bin;
   logic               busy;
   logic               done;
   logic               overflow;
   logic [DIGIT_W-1:0] digit0;
   logic [DIGIT_W-1:0] digit1;
   logic [DIGIT_W-1:0] digit2;
   logic [DIGIT_W-1:0] digit3;

   modport master (
      output start, bin,
      input  busy, done, overflow, digit0, digit1, digit2, digit3
   );

   modport slave (
      input  start, bin,
      output busy, done, overflow, digit0, digit1, digit2, digit3
   );
endinterface

// File: rtl/bin_to_bcd_seq_bcd_add3.sv
// Double-dabble nibble correction: values of 5 or more get +3 before the shift.
module bcd_add3 (
   input  logic [3:0] nibble,
   output logic [3:0] adjusted_c
);
   assign adjusted_c = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD formatter (shift-and-add-3), fixed WIDTH+2 cycle latency.
// Optional macro BCD_BLANK_LEADING_ZEROS_EN blanks leading zero digits (digit3..digit1).
module bin_to_bcd_seq
   import yoda_display_defs::*;
   import bin_to_bcd_seq_pkg::*;
#(
   parameter int unsigned WIDTH  = 14,
   parameter int unsigned DIGITS = 4
) (
   input  logic             clk,
   input  logic             reset,
   bin_to_bcd_seq_if.slave  bus
);
   localparam int unsigned BCD_W   = NIBBLE_W * (DIGITS + 1);
   localparam int unsigned MAX_VAL = max_value(DIGITS);

   state_e                               state_q, state_d;
   logic [WIDTH-1:0]                     sh_q, sh_d;
   logic [BCD_W-1:0]                     bcd_q, bcd_d;
   logic [CNT_W-1:0]                     cnt_q, cnt_d;
   logic                                 ovf_q, ovf_d;
   logic                                 busy_q, busy_d;
   logic                                 done_q, done_d;
   logic                                 overflow_q, overflow_d;
   logic [OUT_DIGITS-1:0][DIGIT_W-1:0]   digits_q, digits_d;

   logic [BCD_W-1:0]                     adj_c;
   logic [OUT_DIGITS-1:0][DIGIT_W-1:0]   fmt_c;
   logic                                 fmt_ovf_c;

   // One nibble adjuster per BCD digit, including the overflow guard nibble.
   for (genvar g = 0; g <= int'(DIGITS); g++) begin : g_add3
      bcd_add3 u_add3 (
         .nibble     (bcd_q[g*NIBBLE_W +: NIBBLE_W]),
         .adjusted_c (adj_c[g*NIBBLE_W +: NIBBLE_W])
      );
   end

   // Display formatting of the finished accumulator.
   always_comb begin
`ifdef BCD_BLANK_LEADING_ZEROS_EN
      logic lead_c;
      lead_c = 1'b1;
`endif
      fmt_ovf_c = ovf_q | (bcd_q[BCD_W-1 -: NIBBLE_W] != '0);
      for (int i = 0; i < int'(OUT_DIGITS); i++) begin
         fmt_c[i] = DIGIT_W'(bcd_q[i*NIBBLE_W +: NIBBLE_W]);
      end
`ifdef BCD_BLANK_LEADING_ZEROS_EN
      for (int i = int'(OUT_DIGITS) - 1; i >= 1; i--) begin
         if (lead_c && (fmt_c[i] == DIGIT_W'(0))) fmt_c[i] = DIGIT_BLANK;
         else                                      lead_c   = 1'b0;
      end
`endif
      if (fmt_ovf_c) fmt_c = {OUT_DIGITS{DIGIT_DASH}};
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d    = state_q;
      sh_d       = sh_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      overflow_d = overflow_q;
      digits_d   = digits_q;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               sh_d    = bus.bin;
               bcd_d   = '0;
               ovf_d   = (32'(bus.bin) > MAX_VAL);
               cnt_d   = CNT_W'(WIDTH);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            {bcd_d, sh_d} = {adj_c[BCD_W-2:0], sh_q, 1'b0};
            cnt_d         = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = FORMAT;
         end
         FORMAT: begin
            digits_d   = fmt_c;
            overflow_d = fmt_ovf_c;
            done_d     = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         sh_q       <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
         digits_q   <= '0;
      end else begin
         state_q    <= state_d;
         sh_q       <= sh_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         overflow_q <= overflow_d;
         digits_q   <= digits_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.overflow = overflow_q;
   assign bus.digit0   = digits_q[0];
   assign bus.digit1   = digits_q[1];
   assign bus.digit2   = digits_q[2];
   assign bus.digit3   = digits_q[3];
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (either BCD_BLANK_LEADING_ZEROS_EN build).
module tb_bin_to_bcd_seq;
   localparam logic [4:0] DASH = 5'h10;
`ifdef BCD_BLANK_LEADING_ZEROS_EN
   localparam logic [4:0] LZ = 5'h1F;
`else
   localparam logic [4:0] LZ = 5'h00;
`endif

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   bin_to_bcd_seq_if #(.WIDTH(14)) bus ();

   bin_to_bcd_seq #(.WIDTH(14), .DIGITS(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_digits(input string tag, input logic [4:0] e3, input logic [4:0] e2,
                               input logic [4:0] e1, input logic [4:0] e0);
      check({tag, "_d3"}, 32'(bus.digit3), 32'(e3));
      check({tag, "_d2"}, 32'(bus.digit2), 32'(e2));
      check({tag, "_d1"}, 32'(bus.digit1), 32'(e1));
      check({tag, "_d0"}, 32'(bus.digit0), 32'(e0));
   endtask

   // Issues start at the current negedge and waits for done; returns in the done cycle.
   task automatic run_conv(input string tag, input logic [13:0] v,
                           input logic [4:0] e3, input logic [4:0] e2,
                           input logic [4:0] e1, input logic [4:0] e0, input logic eo);
      int lat;
      lat = 0;
      bus.start = 1'b1;
      bus.bin   = v;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (k == 1) begin
            check({tag, "_busy_first"}, 32'(bus.busy), 32'd1);
            check({tag, "_done_low"},   32'(bus.done), 32'd0);
         end
         if (k == 15) check({tag, "_busy_format"}, 32'(bus.busy), 32'd1);
         if (bus.done) begin
            lat = k;
            break;
         end
      end
      check({tag, "_latency"}, 32'(lat), 32'd16);
      check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
      check({tag, "_ovf"}, 32'(bus.overflow), 32'(eo));
      check_digits(tag, e3, e2, e1, e0);
   endtask

   initial begin
      int ndone;
      int done_at;
      logic [4:0] cap3, cap2, cap1, cap0;

      n_checks  = 0;
      n_errors  = 0;
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.bin   = '0;
      repeat (3) @(negedge clk);

      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_ovf",  32'(bus.overflow), 32'd0);
      check_digits("rst", 5'd0, 5'd0, 5'd0, 5'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      run_conv("zero", 14'd0, LZ, LZ, LZ, 5'd0, 1'b0);
      repeat (3) @(negedge clk);
      check("zero_done_single", 32'(bus.done), 32'd0);

      run_conv("v1234", 14'd1234, 5'd1, 5'd2, 5'd3, 5'd4, 1'b0);
      run_conv("v9999_b2b", 14'd9999, 5'd9, 5'd9, 5'd9, 5'd9, 1'b0);
      repeat (2) @(negedge clk);

      run_conv("v7", 14'd7, LZ, LZ, LZ, 5'd7, 1'b0);
      repeat (2) @(negedge clk);
      run_conv("v10000", 14'd10000, DASH, DASH, DASH, DASH, 1'b1);
      run_conv("v16383", 14'd16383, DASH, DASH, DASH, DASH, 1'b1);
      repeat (2) @(negedge clk);

      // start while busy is ignored; previous result holds mid-conversion
      ndone   = 0;
      done_at = 0;
      cap3 = '0; cap2 = '0; cap1 = '0; cap0 = '0;
      bus.start = 1'b1;
      bus.bin   = 14'd42;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         bus.start = (k == 5);
         if (k == 5) bus.bin = 14'd55;
         if (k == 10) begin
            check("hold_d0",  32'(bus.digit0), 32'(DASH));
            check("hold_ovf", 32'(bus.overflow), 32'd1);
         end
         if (bus.done) begin
            ndone++;
            if (ndone == 1) begin
               done_at = k;
               cap3 = bus.digit3; cap2 = bus.digit2; cap1 = bus.digit1; cap0 = bus.digit0;
               check("ign_ovf", 32'(bus.overflow), 32'd0);
            end
         end
      end
      check("ign_ndone",   32'(ndone), 32'd1);
      check("ign_latency", 32'(done_at), 32'd16);
      check("ign_d3", 32'(cap3), 32'(LZ));
      check("ign_d2", 32'(cap2), 32'(LZ));
      check("ign_d1", 32'(cap1), 32'd4);
      check("ign_d0", 32'(cap0), 32'd2);

      // reset mid-conversion discards the result
      @(negedge clk);
      bus.start = 1'b1;
      bus.bin   = 14'd4321;
      ndone = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.done) ndone++;
      end
      reset = 1'b1;
      @(negedge clk);
      check("mrst_busy", 32'(bus.busy), 32'd0);
      check("mrst_done", 32'(bus.done), 32'd0);
      check("mrst_ovf",  32'(bus.overflow), 32'd0);
      check_digits("mrst", 5'd0, 5'd0, 5'd0, 5'd0);
      reset = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      check("mrst_no_done", 32'(ndone), 32'd0);
      check("mrst_idle_busy", 32'(bus.busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
